membus_arbiter: RTL and testbench

Two-port arbiter and bus sequencer for the shared 1M×64-bit tagged main-memory bus. It accepts word read/write requests from two masters, port 0 (CPU microengine) and port 1 (I/O/DMA channel), and grants them round-robin. For each granted request it drives the strobed address/data protocol (`o_astb`, `o_rd`, `o_wr`, `o_atomic`) toward `tmemory`. It also enforces atomic read-modify-write locking, so one master can keep exclusive ownership across an operation sequence.

---
 rtl/membus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_membus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// Two-port round-robin arbiter and strobed bus sequencer for the tagged main-memory bus.
// Optional lock timeout is built only when MEMBUS_LOCK_TIMEOUT_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate; a grant latches the request and raises o_astb
// ADDR   | address phase (o_astb=1), next phase chosen by latched we
// RD     | read strobe (o_rd=1), memory answers during the next cycle
// RCAP   | capture i_data/i_tag into the port's rdata/rtag, pulse ack
// WR     | write strobe (o_wr=1) with data/tag, pulse ack
module membus_arbiter #(
   parameter int LOCK_MAX = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [19:0] m0_addr,
   input  logic        m0_we,
   input  logic        m0_atomic,
   input  logic [63:0] m0_wdata,
   input  logic [7:0]  m0_wtag,
   output logic        m0_ack,
   output logic [63:0] m0_rdata,
   output logic [7:0]  m0_rtag,
   input  logic        m1_req,
   input  logic [19:0] m1_addr,
   input  logic        m1_we,
   input  logic        m1_atomic,
   input  logic [63:0] m1_wdata,
   input  logic [7:0]  m1_wtag,
   output logic        m1_ack,
   output logic [63:0] m1_rdata,
   output logic [7:0]  m1_rtag,
   output logic [63:0] o_ad,
   output logic [7:0]  o_tag,
   output logic        o_astb,
   output logic        o_atomic,
   output logic        o_rd,
   output logic        o_wr,
   input  logic [63:0] i_data,
   input  logic [7:0]  i_tag,
   output logic        lock_err
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RD, S_RCAP, S_WR} state_t;

   state_t      state;
   logic        sel, last, lock, owner;
   logic        lat_we, lat_atomic;
   logic [63:0] lat_wdata;
   logic [7:0]  lat_wtag;
   logic        el0, el1, gnt0, gnt1, done;

   // A port whose ack is still high is finishing, not asking again.
   assign el0  = m0_req & ~m0_ack & (~lock | ~owner);
   assign el1  = m1_req & ~m1_ack & (~lock | owner);
   assign gnt1 = (state == S_IDLE) & el1 & (~el0 | ~last);
   assign gnt0 = (state == S_IDLE) & el0 & ~gnt1;
   assign done = (state == S_WR) | (state == S_RCAP);

`ifdef MEMBUS_LOCK_TIMEOUT_EN
   localparam int TW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(LOCK_MAX - 1);
   logic [TW-1:0] tmr;
   logic          owner_el;
   assign owner_el = owner ? el1 : el0;
`else
   assign lock_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         sel        <= 1'b0;
         last       <= 1'b1;
         lock       <= 1'b0;
         owner      <= 1'b0;
         lat_we     <= 1'b0;
         lat_atomic <= 1'b0;
         lat_wdata  <= '0;
         lat_wtag   <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m0_rtag    <= '0;
         m1_rdata   <= '0;
         m1_rtag    <= '0;
         o_ad       <= '0;
         o_tag      <= '0;
         o_astb     <= 1'b0;
         o_atomic   <= 1'b0;
         o_rd       <= 1'b0;
         o_wr       <= 1'b0;
`ifdef MEMBUS_LOCK_TIMEOUT_EN
         tmr        <= '0;
         lock_err   <= 1'b0;
`endif
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt0 | gnt1) begin
                  state      <= S_ADDR;
                  sel        <= gnt1;
                  last       <= gnt1;
                  lat_we     <= gnt1 ? m1_we     : m0_we;
                  lat_atomic <= gnt1 ? m1_atomic : m0_atomic;
                  lat_wdata  <= gnt1 ? m1_wdata  : m0_wdata;
                  lat_wtag   <= gnt1 ? m1_wtag   : m0_wtag;
                  o_ad       <= {44'b0, (gnt1 ? m1_addr : m0_addr)};
                  o_atomic   <= (gnt1 ? m1_atomic : m0_atomic) | lock;
                  o_astb     <= 1'b1;
               end
            end
            S_ADDR: begin
               o_astb <= 1'b0;
               if (lat_we) begin
                  state <= S_WR;
                  o_wr  <= 1'b1;
                  o_ad  <= lat_wdata;
                  o_tag <= lat_wtag;
                  if (sel) m1_ack <= 1'b1;
                  else     m0_ack <= 1'b1;
               end else begin
                  state <= S_RD;
                  o_rd  <= 1'b1;
               end
            end
            S_RD: begin
               state    <= S_RCAP;
               o_rd     <= 1'b0;
               o_atomic <= 1'b0;
            end
            S_RCAP: begin
               state <= S_IDLE;
               if (sel) begin
                  m1_rdata <= i_data;
                  m1_rtag  <= i_tag;
                  m1_ack   <= 1'b1;
               end else begin
                  m0_rdata <= i_data;
                  m0_rtag  <= i_tag;
                  m0_ack   <= 1'b1;
               end
            end
            S_WR: begin
               state    <= S_IDLE;
               o_wr     <= 1'b0;
               o_atomic <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase

         if (done) begin
            if (lat_atomic) begin
               lock  <= 1'b1;
               owner <= sel;
            end else if (lock && (owner == sel)) begin
               lock <= 1'b0;
            end
         end

`ifdef MEMBUS_LOCK_TIMEOUT_EN
         // Down-counts idle cycles of a held lock; reloaded whenever the owner uses it.
         lock_err <= 1'b0;
         if (done && lat_atomic) begin
            tmr <= TMR_LOAD;
         end else if ((state == S_IDLE) && lock) begin
            if (owner_el) begin
               tmr <= TMR_LOAD;
            end else if (tmr == '0) begin
               lock     <= 1'b0;
               lock_err <= 1'b1;
            end else begin
               tmr <= tmr - 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: write/read timing, round-robin, locking, reset, lock timeout.
module tb_membus_arbiter;

   localparam int LMAX = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 0, m0_we = 0, m0_atomic = 0;
   logic [19:0] m0_addr = '0;
   logic [63:0] m0_wdata = '0;
   logic [7:0]  m0_wtag = '0;
   logic        m1_req = 0, m1_we = 0, m1_atomic = 0;
   logic [19:0] m1_addr = '0;
   logic [63:0] m1_wdata = '0;
   logic [7:0]  m1_wtag = '0;
   logic [63:0] i_data = '0;
   logic [7:0]  i_tag = '0;
   logic        m0_ack, m1_ack, o_astb, o_atomic, o_rd, o_wr, lock_err;
   logic [63:0] m0_rdata, m1_rdata, o_ad;
   logic [7:0]  m0_rtag, m1_rtag, o_tag;

   int n_cmp = 0;
   int n_bad = 0;

   membus_arbiter #(.LOCK_MAX(LMAX)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_atomic(m0_atomic),
      .m0_wdata(m0_wdata), .m0_wtag(m0_wtag), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rtag(m0_rtag),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_atomic(m1_atomic),
      .m1_wdata(m1_wdata), .m1_wtag(m1_wtag), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rtag(m1_rtag),
      .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb), .o_atomic(o_atomic), .o_rd(o_rd), .o_wr(o_wr),
      .i_data(i_data), .i_tag(i_tag), .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      m0_req = 0; m1_req = 0; m0_atomic = 0; m1_atomic = 0;
      reset = 0;
      #2;
      reset = 1;
   endtask

   task automatic test_reset();
      reset = 0;
      #23;
      n_cmp++;
      if ({o_astb, o_rd, o_wr, o_atomic, m0_ack, m1_ack, lock_err} !== 7'b0) begin
         n_bad++; $display("FAIL reset_strobes got=%b want=0", {o_astb, o_rd, o_wr, o_atomic, m0_ack, m1_ack, lock_err});
      end
      n_cmp++;
      if ({o_ad, o_tag, m0_rdata, m1_rdata, m0_rtag, m1_rtag} !== '0) begin
         n_bad++; $display("FAIL reset_data got o_ad=%h o_tag=%h m0_rdata=%h m1_rdata=%h want 0", o_ad, o_tag, m0_rdata, m1_rdata);
      end
      reset = 1;
      tick();
      n_cmp++;
      if (o_astb !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle astb got=%b want=0", o_astb);
      end
   endtask

   task automatic test_write();
      m0_addr = 20'h00010; m0_wdata = 64'h1234; m0_wtag = 8'h34; m0_we = 1; m0_atomic = 0; m0_req = 1;
      tick();
      n_cmp++;
      if ({o_astb, o_wr, m0_ack, o_ad} !== {3'b100, 64'h10}) begin
         n_bad++; $display("FAIL wr_addr got astb=%b wr=%b ack=%b ad=%h want 1 0 0 10", o_astb, o_wr, m0_ack, o_ad);
      end
      tick();
      n_cmp++;
      if ({o_astb, o_wr, m0_ack, m1_ack, o_ad, o_tag} !== {4'b0110, 64'h1234, 8'h34}) begin
         n_bad++; $display("FAIL wr_data got astb=%b wr=%b ack0=%b ack1=%b ad=%h tag=%h want 0 1 1 0 1234 34",
                           o_astb, o_wr, m0_ack, m1_ack, o_ad, o_tag);
      end
      m0_req = 0;
      tick();
      n_cmp++;
      if ({o_astb, o_wr, m0_ack} !== 3'b000) begin
         n_bad++; $display("FAIL wr_done got astb=%b wr=%b ack=%b want 000", o_astb, o_wr, m0_ack);
      end
   endtask

   task automatic test_read();
      m0_addr = 20'h808c6; m0_we = 0; m0_atomic = 0; m0_req = 1;
      tick();
      n_cmp++;
      if ({o_astb, o_rd, o_ad} !== {2'b10, 64'h808c6}) begin
         n_bad++; $display("FAIL rd_addr got astb=%b rd=%b ad=%h want 1 0 808c6", o_astb, o_rd, o_ad);
      end
      tick();
      n_cmp++;
      if ({o_astb, o_rd, m0_ack, o_ad} !== {3'b010, 64'h808c6}) begin
         n_bad++; $display("FAIL rd_strobe got astb=%b rd=%b ack=%b ad=%h want 0 1 0 808c6", o_astb, o_rd, m0_ack, o_ad);
      end
      i_data = 64'hdeadbeef00000001; i_tag = 8'h34;
      tick();
      n_cmp++;
      if ({o_astb, o_rd, o_wr, m0_ack} !== 4'b0000) begin
         n_bad++; $display("FAIL rd_cap got astb=%b rd=%b wr=%b ack=%b want 0000", o_astb, o_rd, o_wr, m0_ack);
      end
      tick();
      n_cmp++;
      if ({m0_ack, m1_ack, m0_rdata, m0_rtag} !== {2'b10, 64'hdeadbeef00000001, 8'h34}) begin
         n_bad++; $display("FAIL rd_ack got ack0=%b ack1=%b rdata=%h rtag=%h want 1 0 deadbeef00000001 34",
                           m0_ack, m1_ack, m0_rdata, m0_rtag);
      end
      m0_req = 0; i_data = '0; i_tag = '0;
      tick();
      n_cmp++;
      if ({m0_ack, o_astb, m0_rdata, m0_rtag} !== {2'b00, 64'hdeadbeef00000001, 8'h34}) begin
         n_bad++; $display("FAIL rd_hold got ack=%b astb=%b rdata=%h rtag=%h want 0 0 deadbeef00000001 34",
                           m0_ack, o_astb, m0_rdata, m0_rtag);
      end
   endtask

   task automatic test_back_to_back();
      int k0 = 0, k1 = 0, acks = 0, last_edge = 0, port;
      pulse_reset();
      m0_we = 1; m1_we = 1;
      m0_addr = 20'h100; m0_wdata = 64'hA000_0000_0000_0000;
      m1_addr = 20'h200; m1_wdata = 64'hA000_0000_0000_0100;
      m0_req = 1; m1_req = 1;
      for (int e = 1; e <= 40 && acks < 8; e++) begin
         tick();
         if (o_astb) begin
            n_cmp++;
            if (o_ad !== ((acks % 2 == 0) ? {44'b0, 20'h100 + 20'(k0)} : {44'b0, 20'h200 + 20'(k1)})) begin
               n_bad++; $display("FAIL rr_addr grant=%0d got ad=%h", acks, o_ad);
            end
         end
         if (m0_ack | m1_ack) begin
            port = m1_ack ? 1 : 0;
            n_cmp++;
            if ({m0_ack, m1_ack} !== ((acks % 2 == 0) ? 2'b10 : 2'b01)) begin
               n_bad++; $display("FAIL rr_order ack=%0d got acks=%b want port %0d", acks, {m0_ack, m1_ack}, acks % 2);
            end
            n_cmp++;
            if (o_ad !== (64'hA000_0000_0000_0000 | (64'(port) << 8) | 64'(port ? k1 : k0))) begin
               n_bad++; $display("FAIL rr_wdata ack=%0d got ad=%h", acks, o_ad);
            end
            acks++;
            last_edge = e;
            if (port == 0) begin
               k0++; m0_addr = 20'h100 + 20'(k0); m0_wdata = 64'hA000_0000_0000_0000 | 64'(k0);
               if (k0 == 4) m0_req = 0;
            end else begin
               k1++; m1_addr = 20'h200 + 20'(k1); m1_wdata = 64'hA000_0000_0000_0100 | 64'(k1);
               if (k1 == 4) m1_req = 0;
            end
         end
      end
      n_cmp++;
      if (acks !== 8 || last_edge !== 23) begin
         n_bad++; $display("FAIL rr_count got acks=%0d last_edge=%0d want 8 23", acks, last_edge);
      end
      m0_req = 0; m1_req = 0;
      tick(); tick();
   endtask

   task automatic test_lock();
      int m1_acks = 0;
      bit m0_done = 0;
      pulse_reset();
      i_data = 64'hCAFE_F00D_0000_0042; i_tag = 8'h5A;
      m1_addr = 20'h00055; m1_we = 0; m1_atomic = 1; m1_req = 1;
      tick();
      m0_addr = 20'h00077; m0_we = 1; m0_wdata = 64'h77; m0_atomic = 0; m0_req = 1;
      for (int c = 0; c < 40 && !m0_done; c++) begin
         if (o_astb | o_rd | o_wr) begin
            n_cmp++;
            if (o_atomic !== (m1_acks < 2)) begin
               n_bad++; $display("FAIL lock_oatomic m1_acks=%0d got=%b", m1_acks, o_atomic);
            end
         end
         if (o_astb && m1_acks == 2) begin
            n_cmp++;
            if (o_ad !== 64'h77) begin
               n_bad++; $display("FAIL lock_next_grant got ad=%h want 77", o_ad);
            end
         end
         if (m0_ack) begin
            n_cmp++;
            if (m1_acks !== 2) begin
               n_bad++; $display("FAIL lock_stall m0 acked after %0d port1 acks, want 2", m1_acks);
            end
            m0_done = 1; m0_req = 0;
         end
         if (m1_ack) begin
            m1_acks++;
            if (m1_acks == 1) begin
               n_cmp++;
               if ({m1_rdata, m1_rtag} !== {64'hCAFE_F00D_0000_0042, 8'h5A}) begin
                  n_bad++; $display("FAIL lock_rdata got %h/%h want cafef00d00000042/5a", m1_rdata, m1_rtag);
               end
               m1_addr = 20'h00066; m1_we = 1; m1_atomic = 0; m1_wdata = 64'h66;
            end else begin
               m1_req = 0;
            end
         end
         if (!m0_done) tick();
      end
      n_cmp++;
      if (m0_done !== 1'b1) begin
         n_bad++; $display("FAIL lock_m0_grant got done=%b want 1", m0_done);
      end
      i_data = '0; i_tag = '0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_rd();
      bit saw_ack = 0;
      m0_addr = 20'h12345; m0_we = 0; m0_atomic = 0; m0_req = 1;
      tick();
      tick();
      n_cmp++;
      if (o_rd !== 1'b1) begin
         n_bad++; $display("FAIL rst_rd_phase got rd=%b want 1", o_rd);
      end
      #3;
      reset = 0;
      #1;
      n_cmp++;
      if ({o_astb, o_rd, o_wr, o_atomic, m0_ack, m1_ack, o_ad} !== '0) begin
         n_bad++; $display("FAIL rst_async got astb=%b rd=%b wr=%b atomic=%b ack0=%b ad=%h want 0",
                           o_astb, o_rd, o_wr, o_atomic, m0_ack, o_ad);
      end
      m0_req = 0;
      tick();
      reset = 1;
      m1_addr = 20'h00abc; m1_wdata = 64'h5555; m1_wtag = 8'h99; m1_we = 1; m1_atomic = 0; m1_req = 1;
      tick();
      saw_ack = saw_ack | m0_ack;
      n_cmp++;
      if ({o_astb, o_ad} !== {1'b1, 64'habc}) begin
         n_bad++; $display("FAIL rst_after_addr got astb=%b ad=%h want 1 abc", o_astb, o_ad);
      end
      tick();
      saw_ack = saw_ack | m0_ack;
      n_cmp++;
      if ({o_wr, m1_ack, o_ad, o_tag} !== {2'b11, 64'h5555, 8'h99}) begin
         n_bad++; $display("FAIL rst_after_wr got wr=%b ack1=%b ad=%h tag=%h want 1 1 5555 99", o_wr, m1_ack, o_ad, o_tag);
      end
      m1_req = 0;
      tick();
      saw_ack = saw_ack | m0_ack;
      n_cmp++;
      if ({o_wr, m1_ack, o_astb, saw_ack} !== 4'b0000) begin
         n_bad++; $display("FAIL rst_after_done got wr=%b ack1=%b astb=%b stray_ack0=%b want 0000", o_wr, m1_ack, o_astb, saw_ack);
      end
   endtask

   task automatic test_lock_timeout();
      bit got = 0;
      int cnt = 0;
      pulse_reset();
      m0_addr = 20'h00040; m0_we = 0; m0_atomic = 1; m0_req = 1;
      tick();
      m1_addr = 20'h00041; m1_wdata = 64'h41; m1_we = 1; m1_atomic = 0; m1_req = 1;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         got = m0_ack;
      end
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++; $display("FAIL tmo_m0_ack got=%b want 1", got);
      end
      m0_req = 0; m0_atomic = 0;
`ifdef MEMBUS_LOCK_TIMEOUT_EN
      got = 0;
      for (int c = 0; c < 30 && !got; c++) begin
         tick();
         cnt++;
         got = lock_err;
      end
      n_cmp++;
      if (got !== 1'b1 || cnt !== LMAX) begin
         n_bad++; $display("FAIL tmo_lock_err got seen=%b after=%0d want 1 after %0d", got, cnt, LMAX);
      end
      tick();
      n_cmp++;
      if ({lock_err, o_astb, o_ad} !== {2'b01, 64'h41}) begin
         n_bad++; $display("FAIL tmo_grant got err=%b astb=%b ad=%h want 0 1 41", lock_err, o_astb, o_ad);
      end
      tick();
      n_cmp++;
      if (m1_ack !== 1'b1) begin
         n_bad++; $display("FAIL tmo_m1_ack got=%b want 1", m1_ack);
      end
      m1_req = 0;
      tick();
`else
      for (int c = 0; c < 100; c++) begin
         tick();
         if (m1_ack | o_astb | lock_err) cnt++;
      end
      n_cmp++;
      if (cnt !== 0) begin
         n_bad++; $display("FAIL tmo_held got %0d active cycles for port 1 want 0", cnt);
      end
      pulse_reset();
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_lock();
      test_reset_mid_rd();
      test_lock_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
